// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - two-state instruction fetch unit with a held instruction register and redirect
// Optional FETCH_BOUNDS_CHECK_EN adds a sticky addr_fault output for PC >= MEM_DEPTH.
module instruction_fetch #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter int          MEM_DEPTH = 256
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic        redirect_valid,
  input  logic [15:0] redirect_target,
  output logic [15:0] inst_address,
  input  logic [31:0] read_data,
  output logic        ir_valid,
  input  logic        ir_ready,
  output logic [31:0] instruction,
  output logic [15:0] ir_pc
`ifdef FETCH_BOUNDS_CHECK_EN
  ,
  output logic        addr_fault
`endif
);

  typedef enum logic {
    FETCH = 1'b0,
    HOLD  = 1'b1
  } state_t;

  state_t      state, state_n;
  logic [15:0] pc, pc_n;
  logic        ir_valid_n;
  logic [31:0] instruction_n;
  logic [15:0] ir_pc_n;
  logic        in_range;
  logic        fault_q, fault_n;

  assign inst_address = pc;
  assign in_range     = (32'(pc) < MEM_DEPTH);

`ifdef FETCH_BOUNDS_CHECK_EN
  assign addr_fault = fault_q;
`else
  // Without the bounds check every address is fetchable; the fault flag stays at reset.
  logic unused_in_range;
  assign unused_in_range = in_range;
`endif

  always_comb begin
    state_n       = state;
    pc_n          = pc;
    ir_valid_n    = ir_valid;
    instruction_n = instruction;
    ir_pc_n       = ir_pc;
    fault_n       = fault_q;

    if (redirect_valid) begin
      // Redirect wins everywhere; a coincident handshake is simply absorbed.
      pc_n       = redirect_target;
      ir_valid_n = 1'b0;
      state_n    = FETCH;
      fault_n    = 1'b0;
    end else begin
      case (state)
        FETCH: begin
          if (enable) begin
`ifdef FETCH_BOUNDS_CHECK_EN
            if (!in_range) begin
              fault_n = 1'b1;
            end else begin
              instruction_n = read_data;
              ir_pc_n       = pc;
              pc_n          = pc + 16'd1;
              ir_valid_n    = 1'b1;
              state_n       = HOLD;
            end
`else
            instruction_n = read_data;
            ir_pc_n       = pc;
            pc_n          = pc + 16'd1;
            ir_valid_n    = 1'b1;
            state_n       = HOLD;
`endif
          end
        end
        HOLD: begin
          if (ir_valid && ir_ready) begin
            ir_valid_n = 1'b0;
            state_n    = FETCH;
          end
        end
        default: state_n = FETCH;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= FETCH;
      pc          <= RESET_PC;
      ir_valid    <= 1'b0;
      instruction <= 32'h0;
      ir_pc       <= 16'h0;
      fault_q     <= 1'b0;
    end else begin
      state       <= state_n;
      pc          <= pc_n;
      ir_valid    <= ir_valid_n;
      instruction <= instruction_n;
      ir_pc       <= ir_pc_n;
      fault_q     <= fault_n;
    end
  end

endmodule
